// File: rtl/cache_refill_controller_if.sv
// Bus bundle shared by the L1 miss path, next-level memory and the refill controller.
// The master side is the environment (cache + memory); the slave side is the controller.
interface cache_refill_controller_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 32
);
    logic                    miss_valid;
    logic                    miss_write;
    logic [ADDRESS_BITS-1:0] miss_addr;
    logic [DATA_WIDTH-1:0]   miss_wdata;
    logic                    miss_ready;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDRESS_BITS-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic                    update_out;
    logic [ADDRESS_BITS-1:0] update_addr;
    logic [DATA_WIDTH-1:0]   update_data;
    logic                    refill_done;
    logic                    busy;

    modport master (
        output miss_valid, miss_write, miss_addr, miss_wdata, mem_ack, mem_rdata,
        input  miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  update_out, update_addr, update_data, refill_done, busy
    );

    modport slave (
        input  miss_valid, miss_write, miss_addr, miss_wdata, mem_ack, mem_rdata,
        output miss_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output update_out, update_addr, update_data, refill_done, busy
    );
endinterface

// File: rtl/cache_refill_controller.sv
// L1 miss handler: refills a whole block word by word from memory, or forwards a
// write-through store. One operation at a time; all outputs come straight from flops.
module cache_refill_controller #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OFFSET_BITS  = 3,
    parameter int unsigned ADDRESS_BITS = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    cache_refill_controller_if.slave bus
);
    localparam int unsigned TagBits = ADDRESS_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {StIdle, StRdReq, StFill, StWrReq, StDone} state_e;

    state_e                  state_q, state_d;
    logic [OFFSET_BITS-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [TagBits-1:0]      base_q, base_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [ADDRESS_BITS-1:0] update_addr_q, update_addr_d;
    logic [DATA_WIDTH-1:0]   update_data_q, update_data_d;
    logic                    miss_ready_q, miss_ready_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic                    update_out_q, update_out_d;
    logic                    refill_done_q, refill_done_d;
    logic                    busy_q, busy_d;

    assign cnt_inc = cnt_q + OFFSET_BITS'(1);

    // The counter only ever fills the offset field, so it cannot carry into tag/index bits.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        mem_addr_d    = mem_addr_q;
        update_addr_d = update_addr_q;
        update_data_d = update_data_q;

        case (state_q)
            StIdle: begin
                if (bus.miss_valid) begin
                    base_d  = bus.miss_addr[ADDRESS_BITS-1:OFFSET_BITS];
                    wdata_d = bus.miss_wdata;
                    cnt_d   = '0;
                    if (bus.miss_write) begin
                        state_d    = StWrReq;
                        mem_addr_d = bus.miss_addr;
                    end else begin
                        state_d    = StRdReq;
                        mem_addr_d = {bus.miss_addr[ADDRESS_BITS-1:OFFSET_BITS],
                                      {OFFSET_BITS{1'b0}}};
                    end
                end
            end
            StRdReq: begin
                if (bus.mem_ack) begin
                    update_data_d = bus.mem_rdata;
                    update_addr_d = {base_q, cnt_q};
                    state_d       = StFill;
                end
            end
            StFill: begin
                if (&cnt_q) begin
                    state_d = StDone;
                end else begin
                    cnt_d      = cnt_inc;
                    mem_addr_d = {base_q, cnt_inc};
                    state_d    = StRdReq;
                end
            end
            StWrReq: begin
                if (bus.mem_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Moore outputs are decoded from the next state and registered.
        miss_ready_d  = (state_d == StIdle);
        mem_req_d     = (state_d == StRdReq) || (state_d == StWrReq);
        mem_we_d      = (state_d == StWrReq);
        update_out_d  = (state_d == StFill);
        refill_done_d = (state_d == StDone);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            base_q        <= '0;
            wdata_q       <= '0;
            mem_addr_q    <= '0;
            update_addr_q <= '0;
            update_data_q <= '0;
            miss_ready_q  <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            update_out_q  <= 1'b0;
            refill_done_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            mem_addr_q    <= mem_addr_d;
            update_addr_q <= update_addr_d;
            update_data_q <= update_data_d;
            miss_ready_q  <= miss_ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            update_out_q  <= update_out_d;
            refill_done_q <= refill_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.miss_ready  = miss_ready_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.update_out  = update_out_q;
    assign bus.update_addr = update_addr_q;
    assign bus.update_data = update_data_q;
    assign bus.refill_done = refill_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench: stimulus pushes the expected memory/fill/done events of each operation,
// a negedge monitor with a simple wait-state memory model pops and compares them.
module tb_cache_refill_controller;
    localparam int unsigned DW = 32;
    localparam int unsigned OB = 3;
    localparam int unsigned AW = 32;
    localparam int          B  = 8;

    localparam int KRd   = 0;
    localparam int KFill = 1;
    localparam int KWr   = 2;
    localparam int KDone = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clock;
    logic reset;

    cache_refill_controller_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) bus ();

    cache_refill_controller #(
        .DATA_WIDTH  (DW),
        .OFFSET_BITS (OB),
        .ADDRESS_BITS(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Memory model configuration, written by stimulus between operations.
    int          waits_cfg = 0;
    bit          ack_tied  = 1'b0;
    bit          data_mode = 1'b0;
    int          wait_cnt  = 0;
    bit          mem_waiting = 1'b0;
    logic [31:0] hold_addr;
    logic        hold_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        logic [2:0] lo;
        lo = a[2:0];
        if (!data_mode) return 32'hA0 + {29'b0, lo};
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference behaviour: a read visits every word of the aligned block in order.
    task automatic push_op(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] base;
        if (wr) begin
            push(KWr, a, d);
        end else begin
            base = a & 32'hFFFF_FFF8;
            for (int i = 0; i < B; i++) begin
                push(KRd, base + i, '0);
                push(KFill, base + i, mem_data(base + i));
            end
        end
        push(KDone, '0, '0);
    endtask

    task automatic check_pop(input int k, input logic [31:0] a, input logic [31:0] d,
                             input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected event addr=%0h data=%0h at %0t", name, a, d, $time);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, k, e.kind);
            if (k != KDone) check({name, "_addr"}, a, e.addr);
            if (k == KFill || k == KWr) check({name, "_data"}, d, e.data);
        end
    endtask

    // Monitor and memory responder.
    always @(negedge clock) begin
        if (bus.update_out) check_pop(KFill, bus.update_addr, bus.update_data, "fill");
        if (bus.refill_done) check_pop(KDone, '0, '0, "done");
        if (bus.mem_req) begin
            if (mem_waiting) begin
                check("mem_addr_stable", bus.mem_addr, hold_addr);
                check("mem_we_stable", bus.mem_we, hold_we);
            end
            if (ack_tied || wait_cnt >= waits_cfg) begin
                if (bus.mem_we) check_pop(KWr, bus.mem_addr, bus.mem_wdata, "mem_wr");
                else            check_pop(KRd, bus.mem_addr, '0, "mem_rd");
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_data(bus.mem_addr);
                wait_cnt      = 0;
                mem_waiting   = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wait_cnt++;
                mem_waiting   = 1'b1;
                hold_addr     = bus.mem_addr;
                hold_we       = bus.mem_we;
            end
        end else begin
            bus.mem_ack   = ack_tied;
            bus.mem_rdata = mem_data(bus.mem_addr);
            wait_cnt      = 0;
            mem_waiting   = 1'b0;
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clock);
        bus.miss_valid = 1'b1;
        bus.miss_write = wr;
        bus.miss_addr  = a;
        bus.miss_wdata = d;
        n = 0;
        while (!bus.miss_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("accept_timeout", 1, 0);
        @(posedge clock);
        @(negedge clock);
        bus.miss_valid = 1'b0;
        bus.miss_addr  = $urandom;
        bus.miss_wdata = $urandom;
    endtask

    // Called at the negedge of cycle 1 after acceptance.
    task automatic wait_done(input int lat, input string name);
        int cyc;
        cyc = 1;
        while (!bus.refill_done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check(name, cyc, lat);
    endtask

    task automatic do_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input bit tied, input string name);
        int lat;
        waits_cfg = waits;
        ack_tied  = tied;
        push_op(wr, a, d);
        lat = wr ? (2 + waits) : (2 * B + 1 + B * waits);
        issue(wr, a, d);
        wait_done(lat, name);
    endtask

    initial begin
        int bad;
        int fills;
        bit wr;
        int w;
        bit t;

        reset          = 1'b1;
        bus.miss_valid = 1'b0;
        bus.miss_write = 1'b0;
        bus.miss_addr  = '0;
        bus.miss_wdata = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_miss_ready", bus.miss_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_update_out", bus.update_out, 0);
        check("rst_refill_done", bus.refill_done, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_update_data", bus.update_data, 0);
        reset = 1'b0;

        // Zero-wait refill with ack tied high.
        data_mode = 1'b0;
        do_op(1'b0, 32'h0000_1235, '0, 0, 1'b1, "lat_zero_wait");

        // Three wait states per word.
        do_op(1'b0, 32'h0000_8A5C, '0, 3, 1'b0, "lat_wait3");

        // Store forward with one wait state.
        do_op(1'b1, 32'h0000_4004, 32'hDEAD_BEEF, 1, 1'b0, "lat_store");

        // Back-pressure: second request held during a refill.
        waits_cfg = 0;
        ack_tied  = 1'b1;
        push_op(1'b0, 32'h0000_1235, '0);
        push_op(1'b0, 32'h0000_2000, '0);
        issue(1'b0, 32'h0000_1235, '0);
        bus.miss_valid = 1'b1;
        bus.miss_write = 1'b0;
        bus.miss_addr  = 32'h0000_2000;
        bad = 0;
        for (int i = 0; i < 2000 && !bus.refill_done; i++) begin
            if (bus.miss_ready) bad++;
            @(negedge clock);
        end
        check("bp_ready_low_while_busy", bad, 0);
        check("bp_first_done", bus.refill_done, 1);
        @(negedge clock);
        check("bp_ready_after_done", bus.miss_ready, 1);
        @(negedge clock);
        bus.miss_valid = 1'b0;
        check("bp_busy_second", bus.busy, 1);
        check("bp_mem_addr_second", bus.mem_addr, 32'h0000_2000);
        wait_done(2 * B + 1, "bp_lat_second");

        // Reset in the middle of a refill, during an acked read.
        data_mode = 1'b1;
        waits_cfg = 0;
        ack_tied  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(KRd, 32'h0000_7700 + i, '0);
            if (i < 3) push(KFill, 32'h0000_7700 + i, mem_data(32'h0000_7700 + i));
        end
        issue(1'b0, 32'h0000_7706, '0);
        fills = 0;
        for (int i = 0; i < 200 && fills < 3; i++) begin
            @(negedge clock);
            if (bus.update_out) fills++;
        end
        check("rst_mid_fills", fills, 3);
        @(negedge clock);
        check("rst_mid_req_before", bus.mem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_ready", bus.miss_ready, 1);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_mem_req", bus.mem_req, 0);
        check("rst_mid_update_out", bus.update_out, 0);
        check("rst_mid_done", bus.refill_done, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_mid_queue_drained", exp_q.size(), 0);
        do_op(1'b0, 32'h0000_7706, '0, 0, 1'b0, "rst_mid_restart");

        // Randomized operations.
        for (int i = 0; i < 20; i++) begin
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 2);
            t  = (w == 0) && ($urandom_range(0, 1) == 1);
            do_op(wr, $urandom, $urandom, w, t, "rand_lat");
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
